control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 word_size, default 8, instruction/data width; opcode is instruction[7:4], src is [3:2], dest is [1:0].
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 instruction  input  word_size  current IR contents.
REQ-005 zero  input  1  registered ALU zero flag (Reg_Z).
REQ-006 load_R  output  4  one-hot load enable for R0..R3.
REQ-007 load_PC  output  1  load PC from bus_2.
REQ-008 inc_PC  output  1  increment PC.
REQ-009 load_IR  output  1  load IR from bus_2.
REQ-010 load_Add_R  output  1  load memory address register from bus_2.
REQ-011 load_Reg_Y  output  1  load ALU operand register Y from bus_2.
REQ-012 load_Reg_Z  output  1  capture ALU zero flag.
REQ-013 write  output  1  memory write strobe.
REQ-014 sel_bus_1_mux  output  3  bus_1 source: 0..3=R0..R3, 4=PC.
REQ-015 sel_bus_2_mux  output  2  bus_2 source: 0=alu_out, 1=bus_1, 2=memory word.
REQ-016 alu_sel  output  4  ALU opcode: NOP 0000, ADD 0001, SUB 0010, AND 0011, NOT 0100.
REQ-017 halted  output  1  high while in S_HALT.

Function
REQ-018 Registered state (4-bit); outputs are combinational from state, opcode, src, dest and zero; unlisted outputs are 0 in every state.
REQ-019 S_IDLE: all outputs 0 -> S_FET1.
REQ-020 S_FET1: sel_bus_1=4, sel_bus_2=1, load_Add_R -> S_FET2.
REQ-021 S_FET2: sel_bus_2=2, load_IR, inc_PC -> S_DEC.
REQ-022 S_DEC, NOP: -> S_FET1 with no strobes.
REQ-023 S_DEC, ADD/SUB/AND: sel_bus_1=src, sel_bus_2=1, load_Reg_Y -> S_EX1.
REQ-024 S_DEC, NOT: alu_sel=NOT, sel_bus_1=src, sel_bus_2=0, load_R[dest], load_Reg_Z -> S_FET1.
REQ-025 S_DEC, RD/WR/BR: sel_bus_1=4, sel_bus_2=1, load_Add_R -> S_RD1/S_WR1/S_BR1.
REQ-026 S_DEC, BRZ: zero=1 behaves as BR -> S_BR1; zero=0 asserts inc_PC only (skip operand) -> S_FET1.
REQ-027 S_DEC, opcodes 1001-1111: no strobes -> S_HALT.
REQ-028 S_EX1: alu_sel=opcode, sel_bus_1=dest, sel_bus_2=0, load_R[dest], load_Reg_Z -> S_FET1.
REQ-029 S_RD1/S_WR1: sel_bus_2=2, load_Add_R, inc_PC -> S_RD2/S_WR2.
REQ-030 S_RD2: sel_bus_2=2, load_R[dest] -> S_FET1; S_WR2: sel_bus_1=src, write -> S_FET1.
REQ-031 S_BR1: sel_bus_2=2, load_Add_R -> S_BR2; S_BR2: sel_bus_2=2, load_PC -> S_FET1.
REQ-032 S_HALT: halted=1, no strobes, remains until rst.
REQ-033 alu_sel is NOP in every state/opcode not named in REQ-024/REQ-028.
REQ-034 Latency in cycles from S_FET1 to next S_FET1: NOP 3, NOT 3, ALU 4, BRZ-not-taken 3, RD/WR/BR/BRZ-taken 5.

Reset
REQ-035 rst high at a rising edge forces state to S_IDLE, overriding any transition, including from S_HALT or mid-instruction.
REQ-036 While rst is high all outputs are 0 combinationally, so no load/write/inc strobe escapes in the reset cycle.

Structure
REQ-037 Opcode constants, state encodings and bus-select codes live in a shared package used by the ALU and datapath; no sub-module.

Verification
REQ-038 Reset, instruction=8'b0001_01_10 (ADD R1,R2) -> FET1 load_Add_R; FET2 load_IR+inc_PC; DEC sel_bus_1=1 load_Reg_Y; EX1 alu_sel=0001 sel_bus_1=2 load_R=0100 load_Reg_Z.
REQ-039 instruction=8'h80 (BRZ), zero=0 -> DEC inc_PC=1, next FET1; zero=1 -> BR1 then BR2 load_PC=1, sel_bus_2=2.
REQ-040 instruction=8'b0101_00_11 (RD) -> RD1 inc_PC+load_Add_R; RD2 load_R=1000, sel_bus_2=2.
REQ-041 instruction=8'b0110_10_00 (WR) -> WR2 write=1, sel_bus_1=2, load_R=0000.
REQ-042 instruction=8'hF0 -> S_HALT, halted=1, all strobes 0 for 10 cycles; rst pulse -> S_IDLE, halted=0.
REQ-043 rst asserted during S_EX1 -> load_R=0, load_Reg_Z=0 that cycle; next cycle S_IDLE with all outputs 0.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared encodings for the simple CPU: opcodes, controller states, bus selects, ALU codes.
package control_unit_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_NOT = 4'b0100;
    localparam logic [3:0] OP_RD  = 4'b0101;
    localparam logic [3:0] OP_WR  = 4'b0110;
    localparam logic [3:0] OP_BR  = 4'b0111;
    localparam logic [3:0] OP_BRZ = 4'b1000;

    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_NOT = 4'b0100;

    localparam logic [2:0] BUS1_PC = 3'd4;

    localparam logic [1:0] BUS2_ALU = 2'd0;
    localparam logic [1:0] BUS2_B1  = 2'd1;
    localparam logic [1:0] BUS2_MEM = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_FET1, S_FET2, S_DEC, S_EX1,
        S_RD1, S_RD2, S_WR1, S_WR2, S_BR1, S_BR2, S_HALT
    } state_t;

    function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/control_unit.sv
// Microsequencer for the simple CPU: registered state, combinational strobes
// decoded from state and the instruction register fields.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int word_size = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [word_size-1:0] instruction,
    input  logic                 zero,
    output logic [3:0]           load_R,
    output logic                 load_PC,
    output logic                 inc_PC,
    output logic                 load_IR,
    output logic                 load_Add_R,
    output logic                 load_Reg_Y,
    output logic                 load_Reg_Z,
    output logic                 write,
    output logic [2:0]           sel_bus_1_mux,
    output logic [1:0]           sel_bus_2_mux,
    output logic [3:0]           alu_sel,
    output logic                 halted
);

    state_t     state;
    logic [3:0] opcode;
    logic [1:0] src;
    logic [1:0] dest;

    assign opcode = instruction[7:4];
    assign src    = instruction[3:2];
    assign dest   = instruction[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: state <= S_FET1;
                S_FET1: state <= S_FET2;
                S_FET2: state <= S_DEC;
                S_DEC: begin
                    case (opcode)
                        OP_NOP, OP_NOT:         state <= S_FET1;
                        OP_ADD, OP_SUB, OP_AND: state <= S_EX1;
                        OP_RD:                  state <= S_RD1;
                        OP_WR:                  state <= S_WR1;
                        OP_BR:                  state <= S_BR1;
                        OP_BRZ:                 state <= zero ? S_BR1 : S_FET1;
                        default:                state <= S_HALT;
                    endcase
                end
                S_EX1:  state <= S_FET1;
                S_RD1:  state <= S_RD2;
                S_RD2:  state <= S_FET1;
                S_WR1:  state <= S_WR2;
                S_WR2:  state <= S_FET1;
                S_BR1:  state <= S_BR2;
                S_BR2:  state <= S_FET1;
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes are gated by rst so nothing fires during the reset cycle.
    always_comb begin
        load_R        = 4'b0000;
        load_PC       = 1'b0;
        inc_PC        = 1'b0;
        load_IR       = 1'b0;
        load_Add_R    = 1'b0;
        load_Reg_Y    = 1'b0;
        load_Reg_Z    = 1'b0;
        write         = 1'b0;
        sel_bus_1_mux = 3'd0;
        sel_bus_2_mux = BUS2_ALU;
        alu_sel       = ALU_NOP;
        halted        = 1'b0;
        if (!rst) begin
            case (state)
                S_FET1: begin
                    sel_bus_1_mux = BUS1_PC;
                    sel_bus_2_mux = BUS2_B1;
                    load_Add_R    = 1'b1;
                end
                S_FET2: begin
                    sel_bus_2_mux = BUS2_MEM;
                    load_IR       = 1'b1;
                    inc_PC        = 1'b1;
                end
                S_DEC: begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND: begin
                            sel_bus_1_mux = {1'b0, src};
                            sel_bus_2_mux = BUS2_B1;
                            load_Reg_Y    = 1'b1;
                        end
                        OP_NOT: begin
                            alu_sel       = ALU_NOT;
                            sel_bus_1_mux = {1'b0, src};
                            sel_bus_2_mux = BUS2_ALU;
                            load_R        = reg_onehot(dest);
                            load_Reg_Z    = 1'b1;
                        end
                        OP_RD, OP_WR, OP_BR: begin
                            sel_bus_1_mux = BUS1_PC;
                            sel_bus_2_mux = BUS2_B1;
                            load_Add_R    = 1'b1;
                        end
                        OP_BRZ: begin
                            if (zero) begin
                                sel_bus_1_mux = BUS1_PC;
                                sel_bus_2_mux = BUS2_B1;
                                load_Add_R    = 1'b1;
                            end else begin
                                inc_PC = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                S_EX1: begin
                    alu_sel       = opcode;
                    sel_bus_1_mux = {1'b0, dest};
                    sel_bus_2_mux = BUS2_ALU;
                    load_R        = reg_onehot(dest);
                    load_Reg_Z    = 1'b1;
                end
                S_RD1, S_WR1: begin
                    sel_bus_2_mux = BUS2_MEM;
                    load_Add_R    = 1'b1;
                    inc_PC        = 1'b1;
                end
                S_RD2: begin
                    sel_bus_2_mux = BUS2_MEM;
                    load_R        = reg_onehot(dest);
                end
                S_WR2: begin
                    sel_bus_1_mux = {1'b0, src};
                    write         = 1'b1;
                end
                S_BR1: begin
                    sel_bus_2_mux = BUS2_MEM;
                    load_Add_R    = 1'b1;
                end
                S_BR2: begin
                    sel_bus_2_mux = BUS2_MEM;
                    load_PC       = 1'b1;
                end
                S_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction expected strobe sequences from an
// instruction-level model, compared every cycle.
module tb_control_unit;

    typedef struct packed {
        logic [3:0] ld_r;
        logic       ld_pc;
        logic       inc_pc;
        logic       ld_ir;
        logic       ld_ar;
        logic       ld_y;
        logic       ld_z;
        logic       wr;
        logic [2:0] s1;
        logic [1:0] s2;
        logic [3:0] alu;
        logic       hlt;
    } ov_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] instruction = 8'h00;
    logic       zero = 1'b0;
    logic [3:0] load_R;
    logic       load_PC, inc_PC, load_IR, load_Add_R, load_Reg_Y, load_Reg_Z, write;
    logic [2:0] sel_bus_1_mux;
    logic [1:0] sel_bus_2_mux;
    logic [3:0] alu_sel;
    logic       halted;

    int total = 0;
    int bad   = 0;
    ov_t exp_q[$];

    control_unit #(.word_size(8)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .zero(zero),
        .load_R(load_R), .load_PC(load_PC), .inc_PC(inc_PC), .load_IR(load_IR),
        .load_Add_R(load_Add_R), .load_Reg_Y(load_Reg_Y), .load_Reg_Z(load_Reg_Z),
        .write(write), .sel_bus_1_mux(sel_bus_1_mux), .sel_bus_2_mux(sel_bus_2_mux),
        .alu_sel(alu_sel), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic ov_t observed();
        ov_t o;
        o = {load_R, load_PC, inc_PC, load_IR, load_Add_R, load_Reg_Y, load_Reg_Z,
             write, sel_bus_1_mux, sel_bus_2_mux, alu_sel, halted};
        return o;
    endfunction

    task automatic check(input string tag, input ov_t e);
        ov_t o;
        o = observed();
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected cycle-by-cycle outputs for one instruction, starting at the fetch.
    function automatic void model(input logic [7:0] ins, input logic z, input int halt_cycles);
        ov_t e;
        logic [3:0] op;
        logic [1:0] sr, ds;
        op = ins[7:4];
        sr = ins[3:2];
        ds = ins[1:0];
        exp_q.delete();
        e = '0; e.s1 = 3'd4; e.s2 = 2'd1; e.ld_ar = 1'b1; exp_q.push_back(e);
        e = '0; e.s2 = 2'd2; e.ld_ir = 1'b1; e.inc_pc = 1'b1; exp_q.push_back(e);
        e = '0;
        if (op >= 4'd1 && op <= 4'd3) begin
            e.s1 = {1'b0, sr}; e.s2 = 2'd1; e.ld_y = 1'b1; exp_q.push_back(e);
            e = '0; e.alu = op; e.s1 = {1'b0, ds}; e.ld_r = 4'(1 << ds); e.ld_z = 1'b1;
            exp_q.push_back(e);
        end else if (op == 4'd4) begin
            e.alu = 4'b0100; e.s1 = {1'b0, sr}; e.ld_r = 4'(1 << ds); e.ld_z = 1'b1;
            exp_q.push_back(e);
        end else if (op == 4'd8 && !z) begin
            e.inc_pc = 1'b1; exp_q.push_back(e);
        end else if (op >= 4'd5 && op <= 4'd8) begin
            e.s1 = 3'd4; e.s2 = 2'd1; e.ld_ar = 1'b1; exp_q.push_back(e);
            e = '0; e.s2 = 2'd2; e.ld_ar = 1'b1; e.inc_pc = (op == 4'd5 || op == 4'd6);
            exp_q.push_back(e);
            e = '0;
            if (op == 4'd5) begin
                e.s2 = 2'd2; e.ld_r = 4'(1 << ds);
            end else if (op == 4'd6) begin
                e.s1 = {1'b0, sr}; e.wr = 1'b1;
            end else begin
                e.s2 = 2'd2; e.ld_pc = 1'b1;
            end
            exp_q.push_back(e);
        end else begin
            exp_q.push_back(e);
            if (op != 4'd0) begin
                e.hlt = 1'b1;
                for (int i = 0; i < halt_cycles; i++) exp_q.push_back(e);
            end
        end
    endfunction

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_rst_hold"}, '0);
        tick();
        rst = 1'b0;
        #1;
        check({tag, "_idle"}, '0);
        tick();
    endtask

    // Runs one instruction from FET1; abort_at >= 0 asserts rst at that step instead.
    task automatic run_instr(input string tag, input logic [7:0] ins, input logic z,
                             input int abort_at);
        int n;
        instruction = ins;
        zero = z;
        model(ins, z, 10);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                do_reset({tag, "_abort"});
                return;
            end
            #1;
            check($sformatf("%s_step%0d", tag, i), exp_q[i]);
            tick();
        end
    endtask

    initial begin
        logic [3:0] op;
        logic [7:0] ins;
        rst = 1'b1;
        #1;
        check("reset_out", '0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("post_reset_idle", '0);
        tick();

        run_instr("add_r1_r2", 8'b0001_01_10, 1'b0, -1);
        run_instr("brz_nt", 8'h80, 1'b0, -1);
        run_instr("brz_t", 8'h80, 1'b1, -1);
        run_instr("rd", 8'b0101_00_11, 1'b0, -1);
        run_instr("wr", 8'b0110_10_00, 1'b0, -1);
        run_instr("not", 8'b0100_11_01, 1'b1, -1);
        run_instr("nop", 8'h00, 1'b1, -1);
        run_instr("ex1_rst", 8'b0010_11_01, 1'b0, 3);

        for (int k = 0; k < 40; k++) begin
            op  = 4'($urandom_range(0, 8));
            ins = {op, 4'($urandom_range(0, 15))};
            run_instr($sformatf("rnd%0d", k), ins, 1'($urandom_range(0, 1)), -1);
        end

        run_instr("halt_f0", 8'hF0, 1'b0, -1);
        do_reset("halt_exit");
        run_instr("halt_rnd", {4'($urandom_range(9, 15)), 4'($urandom_range(0, 15))},
                  1'b1, -1);
        do_reset("halt_exit2");
        run_instr("after_halt_add", 8'b0011_00_01, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
